// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexes one shared 4-bit-to-7-segment decoder across NUM_DIGITS
//   common-anode digits. A host word is accepted into a pending buffer through
//   a valid/ready handshake. It is copied into the displayed (shadow) word only
//   in the last cycle of a frame, so a frame never shows a mix of two words.
//   Each digit slot starts with a blanking interval to stop ghosting.
//
// Ports
//   clk         in   rising-edge system clock
//   reset_n     in   asynchronous active-low reset
//   wr_valid    in   host presents wr_data
//   wr_ready    out  pending buffer empty (write accepted when valid & ready)
//   wr_data     in   nibble i is the value of digit i
//   blank_lz    in   1 = suppress leading zeros (sampled at count 0 of a slot)
//   digit_num   out  shared decoder input, 4'hF = blank code
//   digit_en_n  out  active-low digit enables, at most one low
//   frame_tick  out  one-cycle pulse in the last cycle of every frame
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic                    blank_lz,
    output logic [3:0]              digit_num,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pfull_q, pfull_d;
    logic                    lz_q, lz_d;
    logic [3:0]              num_q, num_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic                    tick_q, tick_d;
    logic [0:0]              state_d;
    logic                    last_slot, frame_end, suppress;

    // True when digit idx and every more significant digit are zero.
    function automatic logic upper_zero(input logic [4*NUM_DIGITS-1:0] word,
                                        input logic [IDX_W-1:0]        idx);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx) && word[4*i +: 4] != 4'h0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Outputs are computed from the next-state counter/index/shadow so the
    // registered outputs line up with the counter value of the same cycle.
    always_comb begin
        last_slot = (cnt_q == CNT_LAST);
        frame_end = last_slot && (idx_q == IDX_LAST);

        cnt_d = last_slot ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (last_slot) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

        // Commit is evaluated before acceptance: a write landing in the commit
        // cycle only fills pending and waits for the next frame end.
        shadow_d = shadow_q;
        pend_d   = pend_q;
        pfull_d  = pfull_q;
        if (frame_end && pfull_q) begin
            shadow_d = pend_q;
            pfull_d  = 1'b0;
        end
        if (wr_valid && !pfull_q) begin
            pend_d  = wr_data;
            pfull_d = 1'b1;
        end

        lz_d = (cnt_q == '0) ? blank_lz : lz_q;

        state_d  = (int'(cnt_d) < BLANK_CYCLES) ? ST_BLANK : ST_DRIVE;
        suppress = lz_d && (idx_d != '0) && upper_zero(shadow_d, idx_d);

        num_d = 4'hF;
        en_d  = '1;
        if (state_d == ST_DRIVE && !suppress) begin
            num_d = shadow_d[4*int'(idx_d) +: 4];
            en_d  = ~(NUM_DIGITS'(1) << idx_d);
        end

        tick_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            pend_q   <= '0;
            pfull_q  <= 1'b0;
            lz_q     <= 1'b0;
            num_q    <= 4'hF;
            en_q     <= '1;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            pfull_q  <= pfull_d;
            lz_q     <= lz_d;
            num_q    <= num_d;
            en_q     <= en_d;
            tick_q   <= tick_d;
        end
    end

    assign wr_ready   = ~pfull_q;
    assign digit_num  = num_q;
    assign digit_en_n = en_q;
    assign frame_tick = tick_q;

endmodule
